rgmii_rx_ctrl: RTL and testbench
================================

# rgmii_rx_ctrl

RGMII receive-side controller, the counterpart of the transmit ODDR path. It takes the per-edge nibbles and RX_CTL samples already captured by the input DDR stage and aligned to `sclk`, and reassembles bytes. It decodes RX_DV and RX_ER, strips preamble and SFD, and delivers frame bytes with start/end/error markers to the MAC receive logic. Between frames it decodes the RGMII in-band PHY status.

## Interface
Parameters:
- `PRE_MAX`, 15: maximum number of 0x55 preamble bytes accepted before SFD; more than this aborts the frame.

Ports:
- `sclk`  in  1  125 MHz receive clock. Single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_d_rise`  in  4  nibble captured on the rising edge (byte bits [3:0]).
- `rx_d_fall`  in  4  nibble captured on the falling edge (byte bits [7:4]).
- `rx_ctl_rise`  in  1  RX_CTL on the rising edge; this is RX_DV.
- `rx_ctl_fall`  in  1  RX_CTL on the falling edge; this is RX_DV xor RX_ER.
- `rx_dat`  out  8  frame byte.
- `rx_en`  out  1  `rx_dat` valid.
- `rx_sof`  out  1  first data byte after SFD; qualified by `rx_en`.
- `rx_eof`  out  1  last data byte of the frame; qualified by `rx_en`.
- `rx_err`  out  1  frame had RX_ER during DATA; valid only with `rx_eof`.
- `link_up`  out  1  in-band link status.
- `speed`  out  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- `full_duplex`  out  1  in-band duplex status.

## Operation
- Decode per cycle: byte = {`rx_d_fall`, `rx_d_rise`}; dv = `rx_ctl_rise`; er = `rx_ctl_rise` ^ `rx_ctl_fall`.
- Stage 0 registers all inputs. The FSM acts on the stage-0 values.
- FSM states are DROP, IDLE, PREAMBLE and DATA. The reset state is DROP.
  - DROP: when dv=0, go to IDLE. Nothing is emitted in DROP.
  - IDLE: if dv=1 and byte=0x55, go to PREAMBLE with pre_cnt=1. If dv=1 with any other byte, go to DROP.
  - PREAMBLE:
    - dv=1 and 0x55: increment pre_cnt. If pre_cnt would exceed `PRE_MAX`, go to DROP.
    - dv=1 and 0xD5: go to DATA and arm sof.
    - dv=1 and any other byte: go to DROP.
    - dv=0: go to IDLE.
  - DATA: each dv=1 byte is pushed into a one-byte hold register. When dv=0, go to IDLE and flush the hold register with eof.
- Hold-register emission:
  - When a new byte arrives and the hold register is full, emit the held byte with `rx_en`=1. Assert `rx_sof` if it is the first byte of the frame.
  - When dv falls, emit the held byte with `rx_en`=1 and `rx_eof`=1. Set `rx_err` to the sticky error flag.
- Sticky error flag: set by any cycle in DATA with dv=1 and er=1. Cleared on entry to DATA.
- Zero-length frame (dv falls directly after SFD): nothing is emitted.
- One-byte frame: `rx_sof` and `rx_eof` are both set on the same `rx_en` beat.
- In-band status: update only in cycles with dv=0 and er=0.
  - `link_up` = `rx_d_rise[0]`.
  - `speed` = `rx_d_rise[2:1]`; the code 11 is ignored, so the previous speed is held.
  - `full_duplex` = `rx_d_rise[3]`.
- Status is not updated when dv=0 and er=1 (carrier extend or false carrier), or at any time dv=1.

## Timing
- Reset values: `rx_dat`=0x00, `rx_en`=0, `rx_sof`=0, `rx_eof`=0, `rx_err`=0, `link_up`=0, `speed`=00, `full_duplex`=0. FSM is in DROP; hold register is empty; pre_cnt=0.
- All outputs are registered.
- Data latency: a byte presented in cycle t appears on `rx_dat` in cycle t+3. This holds for the eof beat too: the dv=0 cycle at t+1 triggers the flush.
- `rx_en` is continuous for back-to-back bytes, with no bubbles inside a frame.
- Status latency: input cycle t appears on the outputs in cycle t+2.
- Reset asserted mid-frame: all outputs clear immediately.
- After reset releases with dv already high, the block stays in DROP until dv=0. A partial frame is never emitted.
- The minimum inter-frame gap handled is one dv=0 cycle. Eof of frame N and sof of frame N+1 are never in the same cycle.

## Configuration
- `RGMII_RX_STATUS_EN` defined: in-band status is decoded as described above.
- Not defined: no status logic is built. `link_up`=1, `speed`=10 and `full_duplex`=1 are constants out of reset.

## Test plan
- 7×0x55, 0xD5, data 0x01..0x40 (64 bytes), dv low → 64 `rx_en` beats starting 3 cycles after the first data byte. `rx_sof` on 0x01, `rx_eof` on 0x40, `rx_err`=0.
- Same frame with er=1 on byte 0x20 → all 64 bytes delivered; `rx_err`=1 on the eof beat. The next clean frame gives `rx_err`=0.
- Preamble of 16×0x55, or 0x55 0x5A ..., or dv high with a first byte of 0xAA → no `rx_en`. A following valid frame is received normally.
- SFD followed immediately by dv=0 → no output. SFD, 0x7E, dv=0 → one beat with `rx_dat`=0x7E and `rx_sof`=`rx_eof`=1.
- Idle with `rx_d_rise`=0xD (link, speed 10, full duplex) → `link_up`=1, `speed`=10, `full_duplex`=1 within 2 cycles. Idle with ctl=01 and data 0x0E → status unchanged.
- Assert `rst_n` low at data byte 10 of a frame and release while dv is still high → outputs at reset values, no emission until dv=0, then the next frame is received intact.

Source files
------------

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive controller: byte reassembly, preamble/SFD strip, frame framing.
// Define RGMII_RX_STATUS_EN to build the in-band PHY status decoder.
module rgmii_rx_ctrl #(
  parameter int PRE_MAX = 15
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [3:0] rx_d_rise,
  input  logic [3:0] rx_d_fall,
  input  logic       rx_ctl_rise,
  input  logic       rx_ctl_fall,
  output logic [7:0] rx_dat,
  output logic       rx_en,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       link_up,
  output logic [1:0] speed,
  output logic       full_duplex
);

  localparam int PW = $clog2(PRE_MAX + 2);

  typedef enum logic [1:0] {
    DROP,
    IDLE,
    PREAMBLE,
    DATA
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre_cnt_q;
  logic [PW-1:0] pre_cnt_d;

  logic       s0_vld;
  logic [7:0] s0_byte;
  logic       s0_dv;
  logic       s0_er;

  logic       hold_vld;
  logic [7:0] hold_dat;
  logic       hold_sof;
  logic       sof_arm;
  logic       err_flag;

  logic       push;
  logic       flush;
  logic       arm;

  logic       is_pre;
  logic       is_sfd;
  logic       pre_full;

  // Stage 0: register the captured DDR samples and decode dv/er.
  // s0_vld keeps the FSM in DROP until a real sample follows reset.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld  <= 1'b0;
      s0_byte <= 8'h00;
      s0_dv   <= 1'b0;
      s0_er   <= 1'b0;
    end else begin
      s0_vld  <= 1'b1;
      s0_byte <= {rx_d_fall, rx_d_rise};
      s0_dv   <= rx_ctl_rise;
      s0_er   <= rx_ctl_rise ^ rx_ctl_fall;
    end
  end

  assign is_pre   = (s0_byte == 8'h55);
  assign is_sfd   = (s0_byte == 8'hD5);
  assign pre_full = (pre_cnt_q == PW'(PRE_MAX));

  // FSM state and preamble counter register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DROP;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    push      = 1'b0;
    flush     = 1'b0;
    arm       = 1'b0;
    unique case (state_q)
      DROP: begin
        if (s0_vld && !s0_dv) state_d = IDLE;
      end
      IDLE: begin
        if (s0_dv) begin
          if (is_pre) begin
            state_d   = PREAMBLE;
            pre_cnt_d = PW'(1);
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        unique case (1'b1)
          !s0_dv: state_d = IDLE;
          is_pre: begin
            if (pre_full) begin
              state_d = DROP;
            end else begin
              pre_cnt_d = pre_cnt_q + PW'(1);
            end
          end
          is_sfd: begin
            state_d = DATA;
            arm     = 1'b1;
          end
          default: state_d = DROP;
        endcase
      end
      DATA: begin
        if (s0_dv) begin
          push = 1'b1;
        end else begin
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = DROP;
    endcase
  end

  // Hold register and output beats; the held byte goes out when the
  // next byte arrives or when dv falls (the eof beat).
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_dat <= 8'h00;
      hold_sof <= 1'b0;
      sof_arm  <= 1'b0;
      err_flag <= 1'b0;
      rx_dat   <= 8'h00;
      rx_en    <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_en  <= 1'b0;
      rx_sof <= 1'b0;
      rx_eof <= 1'b0;
      rx_err <= 1'b0;
      if (arm) begin
        hold_vld <= 1'b0;
        sof_arm  <= 1'b1;
        err_flag <= 1'b0;
      end
      if (push) begin
        hold_dat <= s0_byte;
        hold_vld <= 1'b1;
        hold_sof <= sof_arm;
        sof_arm  <= 1'b0;
        if (s0_er) err_flag <= 1'b1;
        if (hold_vld) begin
          rx_en  <= 1'b1;
          rx_dat <= hold_dat;
          rx_sof <= hold_sof;
        end
      end
      if (flush) begin
        hold_vld <= 1'b0;
        sof_arm  <= 1'b0;
        if (hold_vld) begin
          rx_en  <= 1'b1;
          rx_dat <= hold_dat;
          rx_sof <= hold_sof;
          rx_eof <= 1'b1;
          rx_err <= err_flag;
        end
      end
    end
  end

`ifdef RGMII_RX_STATUS_EN
  // In-band status: sampled only in plain idle cycles; speed 11 is held.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      link_up     <= 1'b0;
      speed       <= 2'b00;
      full_duplex <= 1'b0;
    end else if (s0_vld && !s0_dv && !s0_er) begin
      link_up     <= s0_byte[0];
      full_duplex <= s0_byte[3];
      if (s0_byte[2:1] != 2'b11) speed <= s0_byte[2:1];
    end
  end
`else
  assign link_up     = 1'b1;
  assign speed       = 2'b10;
  assign full_duplex = 1'b1;
`endif

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Self-checking bench for rgmii_rx_ctrl: frame scoreboard
// plus a table of in-band status vectors.
module tb_rgmii_rx_ctrl;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rx_d_rise = 4'hD;
  logic [3:0] rx_d_fall = 4'h0;
  logic       rx_ctl_rise = 1'b0;
  logic       rx_ctl_fall = 1'b0;
  logic [7:0] rx_dat;
  logic       rx_en;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic       link_up;
  logic [1:0] speed;
  logic       full_duplex;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic       dv;
    logic       ctl_fall;
    logic [3:0] nib;
    logic       link;
    logic [1:0] spd;
    logic       fd;
  } st_vec_t;
  st_vec_t tbl[8];

  rgmii_rx_ctrl #(.PRE_MAX(15)) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .rx_d_rise   (rx_d_rise),
    .rx_d_fall   (rx_d_fall),
    .rx_ctl_rise (rx_ctl_rise),
    .rx_ctl_fall (rx_ctl_fall),
    .rx_dat      (rx_dat),
    .rx_en       (rx_en),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_err      (rx_err),
    .link_up     (link_up),
    .speed       (speed),
    .full_duplex (full_duplex)
  );

  always #4 sclk = ~sclk;

  always @(posedge sclk) cyc++;

  // Pop one expected beat for each rx_en seen.
  always @(negedge sclk) begin
    if (rst_n && mon_on && rx_en) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat cyc=%0d dat=%h sof=%b eof=%b",
                 cyc, rx_dat, rx_sof, rx_eof);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rx_dat !== e.dat || rx_sof !== e.sof || rx_eof !== e.eof ||
            rx_err !== e.err || cyc != e.cyc) begin
          failures++;
          $display("FAIL beat got dat=%h sof=%b eof=%b err=%b cyc=%0d exp dat=%h sof=%b eof=%b err=%b cyc=%0d",
                   rx_dat, rx_sof, rx_eof, rx_err, cyc,
                   e.dat, e.sof, e.eof, e.err, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic dv,
                       input logic er, output int dc);
    @(posedge sclk);
    #1;
    rx_d_rise   = b[3:0];
    rx_d_fall   = b[7:4];
    rx_ctl_rise = dv;
    rx_ctl_fall = dv ^ er;
    dc = cyc;
  endtask

  task automatic idle(input int n);
    int dc;
    for (int i = 0; i < n; i++) drive(8'h0D, 1'b0, 1'b0, dc);
  endtask

  task automatic frame(input int npre, input int ndata,
                       input logic [7:0] base, input int err_at);
    int dc;
    logic [7:0] b;
    exp_t e;
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    for (int i = 0; i < ndata; i++) begin
      b = base + 8'(i);
      drive(b, 1'b1, i == err_at, dc);
      e.dat = b;
      e.sof = (i == 0);
      e.eof = (i == ndata - 1);
      e.err = (err_at >= 0) && (i == ndata - 1);
      e.cyc = dc + 3;
      q.push_back(e);
    end
    drive(8'h0D, 1'b0, 1'b0, dc);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, req);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    logic [3:0] st;
`ifdef RGMII_RX_STATUS_EN
    st = 4'b0000;
`else
    st = 4'b1101;
`endif
    chk(name, {rx_dat, rx_en, rx_sof, rx_eof, rx_err}, 32'h0);
    chk({name, "_status"}, {link_up, speed, full_duplex}, {28'h0, st});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge sclk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_beats got=%0d exp=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int dc;
    tbl[0] = '{1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'hD, 1'b1, 2'b10, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 4'hE, 1'b1, 2'b10, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'h3, 1'b1, 2'b01, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 4'h7, 1'b1, 2'b01, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'hF, 1'b1, 2'b01, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'h8, 1'b0, 2'b00, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'hD, 1'b1, 2'b10, 1'b1};

    repeat (3) @(posedge sclk);
    #1;
    chk_reset_outs("reset_state");
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    mon_on = 1'b1;
    idle(3);

    // In-band status vectors, each checked two cycles after driving.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_st;
      @(posedge sclk);
      #1;
      rx_d_rise   = tbl[i].nib;
      rx_d_fall   = 4'h0;
      rx_ctl_rise = tbl[i].dv;
      rx_ctl_fall = tbl[i].ctl_fall;
      @(posedge sclk);
      @(posedge sclk);
      @(negedge sclk);
`ifdef RGMII_RX_STATUS_EN
      exp_st = {tbl[i].link, tbl[i].spd, tbl[i].fd};
`else
      exp_st = 4'b1101;
`endif
      chk($sformatf("status_%0d", i),
          {link_up, speed, full_duplex}, {28'h0, exp_st});
    end
    idle(3);

    // Main frame, then errored frame, then clean frame back to back.
    frame(7, 64, 8'h01, -1);
    frame(7, 64, 8'h01, 31);
    frame(7, 64, 8'h01, -1);
    idle(2);
    drain("frames");

    // Preamble length boundary: 15 accepted, 16 aborts.
    frame(15, 3, 8'hA0, -1);
    for (int i = 0; i < 16; i++) drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    for (int i = 0; i < 4; i++) drive(8'(i + 1), 1'b1, 1'b0, dc);
    idle(1);
    drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'h5A, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    drive(8'h01, 1'b1, 1'b0, dc);
    idle(1);
    drive(8'hAA, 1'b1, 1'b0, dc);
    drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    drive(8'h02, 1'b1, 1'b0, dc);
    idle(1);
    frame(7, 5, 8'h30, -1);
    idle(2);
    drain("bad_preamble");

    // Zero-length and one-byte frames.
    frame(7, 0, 8'h00, -1);
    frame(7, 1, 8'h7E, -1);
    idle(2);
    drain("short_frames");

    // Reset mid-frame, released while dv is still high.
    mon_on = 1'b0;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    for (int i = 0; i < 10; i++) drive(8'(i + 1), 1'b1, 1'b0, dc);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("reset_midframe");
    q.delete();
    drive(8'h0B, 1'b1, 1'b0, dc);
    drive(8'h0C, 1'b1, 1'b0, dc);
    rst_n = 1'b1;
    mon_on = 1'b1;
    drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'h55, 1'b1, 1'b0, dc);
    drive(8'hD5, 1'b1, 1'b0, dc);
    drive(8'h11, 1'b1, 1'b0, dc);
    drive(8'h22, 1'b1, 1'b0, dc);
    idle(1);
    frame(7, 8, 8'hC0, -1);
    idle(2);
    drain("after_reset");

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
